// File: rtl/mnet_pkg.sv
// Shared constants, types and helpers for the CNN input pipeline.
package mnet_pkg;

    localparam int INPUT_SIZE     = 32;
    localparam int INPUT_CHANNELS = 3;
    localparam int PX_SIZE        = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_e;

    function automatic int beats_per_frame(input int s, input int c);
        return s * s * c;
    endfunction

    // Index width for a counter with the given extent (never below one bit).
    function automatic int idx_w(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Three-level wrap/carry index counter (ch fastest, then col, then row) for raster-ordered streams.
module raster_counter #(
    parameter int N_CH  = 3,
    parameter int N_COL = 32,
    parameter int N_ROW = 32,
    parameter int CH_W  = mnet_pkg::idx_w(N_CH),
    parameter int COL_W = mnet_pkg::idx_w(N_COL),
    parameter int ROW_W = mnet_pkg::idx_w(N_ROW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CH_W-1:0]  ch,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(N_CH - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(N_COL - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(N_ROW - 1);

    logic [CH_W-1:0]  ch_q,  ch_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        ch_d  = ch_q;
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            ch_d  = '0;
            col_d = '0;
            row_d = '0;
        end else if (inc) begin
            if (ch_q == CH_MAX) begin
                ch_d = '0;
                if (col_q == COL_MAX) begin
                    col_d = '0;
                    row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q  <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            ch_q  <= ch_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign ch   = ch_q;
    assign col  = col_q;
    assign row  = row_q;
    assign last = (ch_q == CH_MAX) && (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/image_frame_loader.sv
// Collects a byte-serial pixel stream into a full-frame register buffer for the CNN core.
// Single buffer: input stalls while a completed frame waits for frame_ready.
module image_frame_loader #(
    parameter int INPUT_SIZE     = mnet_pkg::INPUT_SIZE,
    parameter int INPUT_CHANNELS = mnet_pkg::INPUT_CHANNELS,
    parameter int PX_SIZE        = mnet_pkg::PX_SIZE,
    parameter int COUNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PX_SIZE-1:0]  s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] img_out,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                err_early,
    output logic                err_late,
    output logic [COUNT_W-1:0]  frame_count
);

    import mnet_pkg::*;

    localparam int CH_W  = idx_w(INPUT_CHANNELS);
    localparam int COL_W = idx_w(INPUT_SIZE);
    localparam int ROW_W = idx_w(INPUT_SIZE);

    typedef logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] frame_t;

    loader_state_e      state_q, state_d;
    frame_t             img_q, img_d;
    logic               err_early_q, err_early_d;
    logic               err_late_q, err_late_d;
    logic [COUNT_W-1:0] frame_count_q, frame_count_d;

    logic [CH_W-1:0]    ch;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               last_idx;
    logic               beat;
    logic               early;

    assign s_ready = (state_q == FILL);
    assign beat    = s_valid && s_ready;
    assign early   = beat && s_last && !last_idx;

    // An early s_last abandons the partial frame and restarts at index 0.
    raster_counter #(
        .N_CH  (INPUT_CHANNELS),
        .N_COL (INPUT_SIZE),
        .N_ROW (INPUT_SIZE)
    ) u_raster (
        .clk  (clk),
        .rst  (rst),
        .inc  (beat),
        .clr  (early),
        .ch   (ch),
        .col  (col),
        .row  (row),
        .last (last_idx)
    );

    always_comb begin
        state_d       = state_q;
        frame_count_d = frame_count_q;
        err_early_d   = early;
        err_late_d    = beat && last_idx && !s_last;
        img_d         = img_q;
        unique case (state_q)
            FILL: if (beat && last_idx) state_d = HOLD;
            HOLD: if (frame_ready) begin
                state_d       = FILL;
                frame_count_d = frame_count_q + 1'b1;
            end
        endcase
        if (beat) img_d[row][col][ch] = s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            err_early_q   <= 1'b0;
            err_late_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            err_early_q   <= err_early_d;
            err_late_q    <= err_late_d;
            frame_count_q <= frame_count_d;
        end
    end

    // NOTE: the frame buffer is deliberately not reset; it is only meaningful while frame_valid is high.
    always_ff @(posedge clk) begin
        img_q <= img_d;
    end

    assign img_out     = img_q;
    assign frame_valid = (state_q == HOLD);
    assign err_early   = err_early_q;
    assign err_late    = err_late_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_image_frame_loader.sv
// Self-checking bench for image_frame_loader (4x4x3 frames, 2-bit frame counter).
module tb_image_frame_loader;

    import mnet_pkg::*;

    localparam int S  = 4;
    localparam int C  = 3;
    localparam int P  = 8;
    localparam int CW = 2;
    localparam int N  = beats_per_frame(S, C);

    logic                clk = 1'b0;
    logic                rst;
    logic [P-1:0]        s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;
    logic [S-1:0][S-1:0][C-1:0][P-1:0] img_out;
    logic                frame_valid;
    logic                frame_ready;
    logic                err_early;
    logic                err_late;
    logic [CW-1:0]       frame_count;

    image_frame_loader #(
        .INPUT_SIZE     (S),
        .INPUT_CHANNELS (C),
        .PX_SIZE        (P),
        .COUNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .img_out     (img_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .err_early   (err_early),
        .err_late    (err_late),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: beat index, hold flag, handoff count and the frame as a flat sample list.
    int          m_k     = 0;
    bit          m_hold  = 1'b0;
    int          m_count = 0;
    bit          m_early = 1'b0;
    bit          m_late  = 1'b0;
    logic [7:0]  m_img[$];

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       fr;
        logic       e_ready;
        logic       e_fv;
        logic       e_early;
        logic       e_late;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[6];
    logic [1:0] cnt_exp[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] px(input int k);
        logic [1:0] r, c, h;
        r = 2'(k / (S * C));
        c = 2'((k / C) % S);
        h = 2'(k % C);
        return img_out[r][c][h];
    endfunction

    task automatic model_update(input logic v, input logic [7:0] d, input logic l,
                                input logic fr, input logic r);
        m_early = 1'b0;
        m_late  = 1'b0;
        if (r) begin
            m_k     = 0;
            m_hold  = 1'b0;
            m_count = 0;
        end else if (m_hold) begin
            if (fr) begin
                m_hold  = 1'b0;
                m_count = m_count + 1;
            end
        end else if (v) begin
            m_img[m_k] = d;
            if (m_k == N - 1) begin
                m_hold = 1'b1;
                m_late = !l;
                m_k    = 0;
            end else if (l) begin
                m_early = 1'b1;
                m_k     = 0;
            end else begin
                m_k = m_k + 1;
            end
        end
    endtask

    task automatic check_outputs();
        check("s_ready",     32'(s_ready),     32'(!m_hold));
        check("frame_valid", 32'(frame_valid), 32'(m_hold));
        check("err_early",   32'(err_early),   32'(m_early));
        check("err_late",    32'(err_late),    32'(m_late));
        check("frame_count", 32'(frame_count), 32'(m_count % (1 << CW)));
        if (m_hold) begin
            for (int k = 0; k < N; k++) check("img_hold", 32'(px(k)), 32'(m_img[k]));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check on the falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic fr, input logic r);
        s_valid     = v;
        s_data      = d;
        s_last      = l;
        frame_ready = fr;
        rst         = r;
        @(posedge clk);
        model_update(v, d, l, fr, r);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    endtask

    // mode 0: data k, mode 1: data 255-k, otherwise random; beats 0..stop_at, s_last on stop_at if with_last.
    task automatic send_frame(input int mode, input int stop_at, input bit with_last);
        logic [7:0] d;
        for (int k = 0; k <= stop_at; k++) begin
            repeat ($urandom_range(0, 2)) idle();
            d = (mode == 0) ? 8'(k) : (mode == 1) ? 8'(255 - k) : 8'($urandom);
            step(1'b1, d, (k == stop_at) ? with_last : 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_frame(input int mode);
        logic [7:0] e;
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++)
                for (int h = 0; h < C; h++) begin
                    e = (mode == 0) ? 8'(r * 12 + c * 3 + h) : 8'(255 - (r * 12 + c * 3 + h));
                    check("frame_px", 32'(px(r * 12 + c * 3 + h)), 32'(e));
                end
    endtask

    task automatic handoff();
        step(1'b0, 8'($urandom), 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (N) m_img.push_back(8'hxx);
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; frame_ready = 1'b0; rst = 1'b1;

        //           r     v     d      l     fr    rdy   fv    early late  cnt
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[2] = '{1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].fr, tbl[i].r);
            check("tbl_ready", 32'(s_ready),     32'(tbl[i].e_ready));
            check("tbl_fv",    32'(frame_valid), 32'(tbl[i].e_fv));
            check("tbl_early", 32'(err_early),   32'(tbl[i].e_early));
            check("tbl_late",  32'(err_late),    32'(tbl[i].e_late));
            check("tbl_count", 32'(frame_count), 32'(tbl[i].e_cnt));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset after beat 20: progress discarded, next frame starts at index 0.
        send_frame(2, 20, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("rst_fv",    32'(frame_valid), 32'(0));
        check("rst_count", 32'(frame_count), 32'(0));
        send_frame(0, N - 1, 1'b1);
        check("fv_latency", 32'(frame_valid), 32'(1));
        check_frame(0);

        // Stall in HOLD with s_valid high, then hand off and load the inverted frame.
        repeat (20) begin
            step(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
            check("hold_ready", 32'(s_ready), 32'(0));
        end
        check_frame(0);
        handoff();
        check("count_after_handoff", 32'(frame_count), 32'(1));
        check("ready_after_handoff", 32'(s_ready), 32'(1));
        send_frame(1, N - 1, 1'b1);
        check_frame(1);
        handoff();

        // Early s_last on beat 10.
        send_frame(2, 10, 1'b1);
        check("early_pulse", 32'(err_early),   32'(1));
        check("early_fv",    32'(frame_valid), 32'(0));
        idle();
        check("early_clear", 32'(err_early), 32'(0));
        send_frame(1, N - 1, 1'b1);
        check_frame(1);
        handoff();

        // Missing s_last on the final beat: frame kept, err_late coincident with frame_valid.
        send_frame(0, N - 1, 1'b0);
        check("late_pulse", 32'(err_late),    32'(1));
        check("late_fv",    32'(frame_valid), 32'(1));
        check_frame(0);
        idle();
        check("late_clear", 32'(err_late), 32'(0));
        handoff();

        // Counter wrap with a 2-bit frame_count.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_frame(2, N - 1, 1'b1);
            handoff();
            check("count_seq", 32'(frame_count), 32'(cnt_exp[i]));
        end

        // Random soak against the model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 500) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
